adxl362_spi_master: RTL and testbench
=====================================

Name: adxl362_spi_master

Overview:
SPI mode-0 initiator (CPOL=0, CPHA=0) that drives ADXL362 transactions from the system side: register write (0x0A), register read (0x0B) and FIFO read (0x0D).
- Sits between the test/control logic and the ADXL362 SPI slave model. SCLK/MOSI/nCS/MISO connect pin-for-pin to the slave.
- Accepts one command per handshake and serialises command byte, address byte and N data bytes.
- Streams write data in and read data out byte by byte.

Parameters:
CLK_DIV, 4, clk_sys cycles per SCLK half-period; legal range 2..255.
LEN_W, 5, width of cmd_len; maximum data bytes per transaction is 2^LEN_W-1.
CS_IDLE, 4, minimum clk_sys cycles nCS stays high between transactions.

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a transfer occurs when cmd_valid && cmd_ready
cmd_op  in  2  0=register write, 1=register read, 2=FIFO read, 3=reserved
cmd_addr  in  6  start register address (ignored for FIFO read)
cmd_len  in  LEN_W  number of data bytes after the header
wr_data  in  8  next write byte
wr_valid  in  1  wr_data valid
wr_ready  out  1  one-cycle pulse: wr_data consumed
rd_data  out  8  received byte; held until the next rd_valid
rd_valid  out  1  one-cycle pulse per received data byte
busy  out  1  high from the accepted command until cmd_ready returns
done  out  1  one-cycle pulse when nCS deasserts at transaction end
SCLK  out  1  SPI clock, idle low
MOSI  out  1  SPI data out, MSB first
MISO  in  1  SPI data in
nCS  out  1  chip select, active-low

Behaviour:
- Reset values: nCS=1, SCLK=0, MOSI=0, cmd_ready=0 during the reset cycle and 1 afterwards, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0. All counters clear. Reset mid-transaction aborts immediately: nCS=1 and SCLK=0 on the next cycle, with no done pulse.
- Accept cycle: latch op, addr and len; set busy=1.
  - Op 0 header byte = 0x0A; op 1 header = 0x0B; op 2 header = 0x0D.
  - Address byte = {2'b00, addr}.
  - Op 3: no SPI activity; done pulses one cycle after accept.
- State machine:
  - IDLE -> CS_SETUP: on accept; nCS=0 and MOSI = bit 7 of the header.
  - CS_SETUP -> SHIFT: after CLK_DIV cycles.
  - SHIFT, per bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. MISO is sampled into the shift register on the cycle SCLK goes 0->1. MOSI updates to the next bit on the cycle SCLK goes 1->0. Eight bits per byte.
  - SHIFT -> NEXT_BYTE: after the 8th high phase, SCLK=0.
  - NEXT_BYTE:
    - If the byte just finished was a data byte of a read or FIFO op, drive rd_data = shifted byte and pulse rd_valid.
    - If more bytes remain, load the next byte and return to SHIFT. For a write data byte: if wr_valid=1, load wr_data and pulse wr_ready; if wr_valid=0, stall here (nCS=0, SCLK=0) until wr_valid=1.
    - Read/FIFO data bytes transmit 0x00.
    - If no bytes remain, go to CS_HOLD.
  - CS_HOLD -> CS_WAIT: after CLK_DIV cycles with SCLK=0; set nCS=1 and pulse done.
  - CS_WAIT -> IDLE: after CS_IDLE cycles.
- Byte sequence:
  - Op 0 and op 1: header, address, then cmd_len data bytes.
  - Op 2: header, then cmd_len data bytes (no address byte).
  - cmd_len=0 is legal: header only (op 2) or header plus address (ops 0/1).
- MOSI changes only while SCLK=0. SCLK never toggles while nCS=1.
- Bit counter wraps 7->0 at each byte boundary. Byte counter counts down; no underflow past 0.
- cmd_valid is ignored while busy. A wr_valid byte presented before it is needed is held by the source, not buffered.

Optional Feature:
ADXL362_SPI_MASTER_ABORT_EN
- With the macro defined, add input port abort (1 bit).
  - abort=1 while busy sets a sticky abort flag.
  - At the next NEXT_BYTE entry, including a write stall, the block goes straight to CS_HOLD.
  - The completed byte's rd_valid still fires; no further wr_ready or rd_valid pulses occur; done pulses normally.
  - abort in IDLE has no effect. The flag clears on rst or on entry to IDLE.
- Without the macro: no abort port, and transactions always run to cmd_len.

Test Plan:
- Register write, CLK_DIV=4: op0, addr 0x2D, len 1, wr_data 0x02 -> MOSI bytes 0x0A, 0x2D, 0x02; 24 SCLK rising edges; each SCLK high and low phase lasts 4 cycles; one wr_ready; done once; nCS high at least 4 cycles before cmd_ready.
- Burst read: op1, addr 0x0E, len 3, slave returns 0x11, 0x22, 0x33 -> three rd_valid pulses with rd_data 0x11, 0x22, 0x33; MOSI data bytes 0x00.
- FIFO read: op2, len 4 -> MOSI header 0x0D with no address byte; 40 SCLK edges; 4 rd_valid pulses.
- Write stall: op0, len 2, wr_valid low for 50 cycles after the first data byte -> SCLK held low and nCS low for the stall; second byte is sent once wr_valid=1.
- Reset mid-byte: assert rst during the 5th bit of the address byte -> next cycle nCS=1, SCLK=0, no done pulse; then a fresh op1 completes correctly.
- Edge cases: op3 -> no nCS activity, done one cycle after accept. cmd_len=0 with op1 -> exactly 16 SCLK edges.

Source files
------------

// File: rtl/adxl362_spi_master_if.sv
// Command / write-stream / read-stream handshake bundle for adxl362_spi_master.
interface adxl362_spi_master_if #(
    parameter int unsigned LEN_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [5:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 initiator for ADXL362 register write/read and FIFO read transactions.
// Optional ADXL362_SPI_MASTER_ABORT_EN adds an abort input that ends the transfer at the next byte boundary.
module adxl362_spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned CS_IDLE = 4
) (
    input  logic                clk_sys,
    input  logic                rst,
`ifdef ADXL362_SPI_MASTER_ABORT_EN
    input  logic                abort,
`endif
    adxl362_spi_master_if.slave bus,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO,
    output logic                nCS
);
    localparam int unsigned     CNT_W     = 8;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(CS_IDLE - 1);
    localparam logic [1:0]      OP_WR     = 2'd0;
    localparam logic [1:0]      OP_RD     = 2'd1;
    localparam logic [1:0]      OP_FIFO   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_SHIFT, S_NEXT_BYTE, S_CS_HOLD, S_CS_WAIT, S_RSVD
    } state_t;
    typedef enum logic [1:0] {K_HDR, K_ADDR, K_DATA} kind_t;

    state_t           state_q, state_d;
    kind_t            kind_q, kind_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic [5:0]       addr_q, addr_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             sclk_q, sclk_d, mosi_q, mosi_d, ncs_q, ncs_d;
    logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d, done_q, done_d;
    logic             wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
    logic             load_c;
    logic [7:0]       tx_c, hdr_c;

`ifdef ADXL362_SPI_MASTER_ABORT_EN
    logic abort_q, abort_d;
`else
    logic abort_q;
    assign abort_q = 1'b0;
`endif

    always_comb begin
        case (bus.cmd_op)
            OP_RD:   hdr_c = 8'h0B;
            OP_FIFO: hdr_c = 8'h0D;
            default: hdr_c = 8'h0A;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        div_d      = div_q;
        bit_d      = bit_q;
        rem_d      = rem_q;
        op_d       = op_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        rd_data_d  = rd_data_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ncs_d      = ncs_q;
        done_d     = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        load_c     = 1'b0;
        tx_c       = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d   = bus.cmd_op;
                    addr_d = bus.cmd_addr;
                    rem_d  = bus.cmd_len;
                    div_d  = '0;
                    bit_d  = '0;
                    if (bus.cmd_op == 2'd3) begin
                        state_d = S_RSVD;
                    end else begin
                        state_d = S_CS_SETUP;
                        kind_d  = K_HDR;
                        ncs_d   = 1'b0;
                        shreg_d = hdr_c;
                        mosi_d  = hdr_c[7];
                    end
                end
            end
            S_RSVD: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + CNT_W'(1);
                end else begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        shreg_d = {shreg_q[6:0], MISO};
                    end else if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_NEXT_BYTE;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        mosi_d = shreg_q[7];
                    end
                end
            end
            S_NEXT_BYTE: begin
                if (kind_q == K_DATA && op_q != OP_WR) begin
                    rd_data_d  = shreg_q;
                    rd_valid_d = 1'b1;
                end
                if (abort_q) begin
                    state_d = S_CS_HOLD;
                    div_d   = '0;
                end else if (kind_q == K_HDR && op_q != OP_FIFO) begin
                    load_c = 1'b1;
                    tx_c   = {2'b00, addr_q};
                    kind_d = K_ADDR;
                end else if (rem_q != '0) begin
                    // Write data is taken only when the source offers it; otherwise hold SCLK low here
                    if (op_q != OP_WR || bus.wr_valid) begin
                        load_c     = 1'b1;
                        tx_c       = (op_q == OP_WR) ? bus.wr_data : 8'h00;
                        wr_ready_d = (op_q == OP_WR);
                        kind_d     = K_DATA;
                        rem_d      = rem_q - LEN_W'(1);
                    end
                end else begin
                    state_d = S_CS_HOLD;
                    div_d   = '0;
                end
                // Start at 1 so this cycle counts toward the first low phase of the new byte
                if (load_c) begin
                    shreg_d = tx_c;
                    mosi_d  = tx_c[7];
                    div_d   = CNT_W'(1);
                    state_d = S_SHIFT;
                end
            end
            S_CS_HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_CS_WAIT;
                    div_d   = '0;
                    ncs_d   = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            S_CS_WAIT: begin
                if (div_q == IDLE_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);

`ifdef ADXL362_SPI_MASTER_ABORT_EN
        abort_d = abort_q | (abort & busy_q);
        if (state_d == S_IDLE) abort_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= K_HDR;
            div_q       <= '0;
            bit_q       <= '0;
            rem_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            shreg_q     <= '0;
            rd_data_q   <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ncs_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
`ifdef ADXL362_SPI_MASTER_ABORT_EN
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            shreg_q     <= shreg_d;
            rd_data_q   <= rd_data_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ncs_q       <= ncs_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
`ifdef ADXL362_SPI_MASTER_ABORT_EN
            abort_q     <= abort_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign SCLK          = sclk_q;
    assign MOSI          = mosi_q;
    assign nCS           = ncs_q;
endmodule

// File: tb/tb_adxl362_spi_master.sv
// Directed self-checking bench for adxl362_spi_master with a behavioural ADXL362 SPI slave/monitor.
module tb_adxl362_spi_master;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned CS_IDLE = 4;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    logic SCLK, MOSI, MISO, nCS;
`ifdef ADXL362_SPI_MASTER_ABORT_EN
    logic abort = 1'b0;
`endif

    adxl362_spi_master_if #(.LEN_W(LEN_W)) bus ();

    adxl362_spi_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_IDLE(CS_IDLE)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
`ifdef ADXL362_SPI_MASTER_ABORT_EN
        .abort   (abort),
`endif
        .bus     (bus),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .nCS     (nCS)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Slave/monitor state: written only by the monitor process
    int         ncs_falls = 0, done_cnt = 0, wrr_cnt = 0, rd_n = 0, idle_bad = 0;
    int         rises = 0, high_bad = 0, low_bad = 0, low_max = 0, mosi_bad = 0, mb_n = 0;
    int         high_len = 0, low_len = 0;
    bit         fall_seen = 0;
    logic [7:0] rd_log [64];
    logic [7:0] mb [48];
    logic [7:0] mosi_sh = 8'h00;
    logic       sclk_p = 1'b0, ncs_p = 1'b1, mosi_p = 1'b0;
    logic [3:0] s_byte = 4'd0;
    logic [2:0] s_bit = 3'd0;

    // Stimulus tables: written only by the test tasks
    logic [7:0] miso_tab [16];
    logic [7:0] wr_tab [16];

    assign MISO = miso_tab[s_byte][3'd7 - s_bit];

    always @(negedge clk_sys) begin : mon
        logic [7:0] nv;
        if (ncs_p === 1'b1 && nCS === 1'b0) begin
            ncs_falls++;
            rises = 0; high_bad = 0; low_bad = 0; low_max = 0; mosi_bad = 0; mb_n = 0;
            fall_seen = 0; low_len = 0; high_len = 0; s_byte = 4'd0; s_bit = 3'd0;
        end
        if (nCS === 1'b1 && ncs_p === 1'b1 && SCLK !== sclk_p) idle_bad++;
        if (nCS === 1'b0) begin
            if (SCLK === 1'b1 && sclk_p === 1'b0) begin
                rises++;
                if (fall_seen && low_len != int'(CLK_DIV)) low_bad++;
                high_len = 1;
                nv = {mosi_sh[6:0], MOSI};
                mosi_sh = nv;
                if (s_bit == 3'd7) begin
                    if (mb_n < 48) mb[mb_n] = nv;
                    mb_n++;
                    s_byte = s_byte + 4'd1;
                end
                s_bit = s_bit + 3'd1;
            end else if (SCLK === 1'b1) begin
                high_len++;
            end else if (sclk_p === 1'b1) begin
                if (high_len != int'(CLK_DIV)) high_bad++;
                fall_seen = 1;
                low_len = 1;
            end else begin
                low_len++;
                if (low_len > low_max) low_max = low_len;
            end
            if (SCLK === 1'b1 && MOSI !== mosi_p) mosi_bad++;
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.wr_ready === 1'b1) wrr_cnt++;
        if (bus.rd_valid === 1'b1) begin
            rd_log[6'(rd_n)] = bus.rd_data;
            rd_n++;
        end
        sclk_p = SCLK;
        ncs_p  = nCS;
        mosi_p = MOSI;
    end

    task automatic issue_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [LEN_W-1:0] len);
        int n;
        @(negedge clk_sys);
        bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_len = len; bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin @(negedge clk_sys); n++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_timeout got %b exp 1", bus.cmd_ready); end
        @(negedge clk_sys);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_xfer(input logic [1:0] op, input logic [5:0] addr, input logic [LEN_W-1:0] len,
                           input int hold_after_first, output int gap);
        int widx, hold;
        bit seen_done, ok;
        widx = 0; hold = 0; gap = 0; seen_done = 0; ok = 0;
        issue_cmd(op, addr, len);
        for (int n = 0; n < 4000; n++) begin
            if (bus.wr_ready === 1'b1) begin
                widx++;
                if (widx == 1) hold = hold_after_first;
            end else if (hold > 0) begin
                hold--;
            end
            bus.wr_valid = (op == 2'd0) && (widx < int'(len)) && (hold == 0);
            bus.wr_data  = wr_tab[4'(widx)];
            if (bus.done === 1'b1) seen_done = 1;
            if (seen_done && nCS === 1'b1 && bus.cmd_ready !== 1'b1) gap++;
            if (bus.cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge clk_sys);
        end
        bus.wr_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL xfer_timeout op %0d got no completion exp completion", op); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        checks++; if (nCS !== 1'b1) begin errors++; $display("FAIL rst_ncs got %b exp 1", nCS); end
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", SCLK); end
        checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", MOSI); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", bus.cmd_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b exp 0", bus.wr_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", bus.rd_data); end
        rst = 1'b0;
        @(negedge clk_sys);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready got %b exp 1", bus.cmd_ready); end
    endtask

    task automatic test_reg_write();
        int gap, w0, d0, r0;
        logic [7:0] exp_b [3];
        exp_b = '{8'h0A, 8'h2D, 8'h02};
        wr_tab[0] = 8'h02;
        w0 = wrr_cnt; d0 = done_cnt; r0 = rd_n;
        do_xfer(2'd0, 6'h2D, 5'd1, 0, gap);
        checks++; if (mb_n != 3) begin errors++; $display("FAIL wr_nbytes got %0d exp 3", mb_n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mb[i] !== exp_b[i]) begin errors++; $display("FAIL wr_mosi[%0d] got %h exp %h", i, mb[i], exp_b[i]); end
        end
        checks++; if (rises != 24) begin errors++; $display("FAIL wr_rises got %0d exp 24", rises); end
        checks++; if (high_bad != 0) begin errors++; $display("FAIL wr_high_phase bad %0d exp 0", high_bad); end
        checks++; if (low_bad != 0) begin errors++; $display("FAIL wr_low_phase bad %0d exp 0", low_bad); end
        checks++; if (mosi_bad != 0) begin errors++; $display("FAIL wr_mosi_while_high got %0d exp 0", mosi_bad); end
        checks++; if (wrr_cnt - w0 != 1) begin errors++; $display("FAIL wr_ready_count got %0d exp 1", wrr_cnt - w0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wr_done_count got %0d exp 1", done_cnt - d0); end
        checks++; if (rd_n - r0 != 0) begin errors++; $display("FAIL wr_rd_valid_count got %0d exp 0", rd_n - r0); end
        checks++; if (gap < int'(CS_IDLE)) begin errors++; $display("FAIL wr_cs_idle got %0d exp >=%0d", gap, CS_IDLE); end
    endtask

    task automatic test_burst_read();
        int gap, d0, r0;
        logic [7:0] exp_b [3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        miso_tab[0] = 8'hA5; miso_tab[1] = 8'h5A;
        miso_tab[2] = 8'h11; miso_tab[3] = 8'h22; miso_tab[4] = 8'h33;
        d0 = done_cnt; r0 = rd_n;
        do_xfer(2'd1, 6'h0E, 5'd3, 0, gap);
        checks++; if (mb[0] !== 8'h0B) begin errors++; $display("FAIL rd_hdr got %h exp 0B", mb[0]); end
        checks++; if (mb[1] !== 8'h0E) begin errors++; $display("FAIL rd_addr got %h exp 0E", mb[1]); end
        for (int i = 2; i < 5; i++) begin
            checks++; if (mb[i] !== 8'h00) begin errors++; $display("FAIL rd_mosi_data[%0d] got %h exp 00", i, mb[i]); end
        end
        checks++; if (rises != 40) begin errors++; $display("FAIL rd_rises got %0d exp 40", rises); end
        checks++; if (rd_n - r0 != 3) begin errors++; $display("FAIL rd_valid_count got %0d exp 3", rd_n - r0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_log[6'(r0 + i)] !== exp_b[i]) begin
                errors++; $display("FAIL rd_data[%0d] got %h exp %h", i, rd_log[6'(r0 + i)], exp_b[i]);
            end
        end
        checks++; if (bus.rd_data !== 8'h33) begin errors++; $display("FAIL rd_data_hold got %h exp 33", bus.rd_data); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rd_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_fifo_read();
        int gap, r0;
        logic [7:0] exp_b [4];
        exp_b = '{8'hC3, 8'h81, 8'h7E, 8'h01};
        miso_tab[0] = 8'h5A;
        for (int i = 0; i < 4; i++) miso_tab[i + 1] = exp_b[i];
        r0 = rd_n;
        do_xfer(2'd2, 6'h3F, 5'd4, 0, gap);
        checks++; if (mb_n != 5) begin errors++; $display("FAIL fifo_nbytes got %0d exp 5", mb_n); end
        checks++; if (mb[0] !== 8'h0D) begin errors++; $display("FAIL fifo_hdr got %h exp 0D", mb[0]); end
        checks++; if (mb[1] !== 8'h00) begin errors++; $display("FAIL fifo_no_addr got %h exp 00", mb[1]); end
        checks++; if (rises != 40) begin errors++; $display("FAIL fifo_rises got %0d exp 40", rises); end
        checks++; if (rd_n - r0 != 4) begin errors++; $display("FAIL fifo_rd_valid_count got %0d exp 4", rd_n - r0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_log[6'(r0 + i)] !== exp_b[i]) begin
                errors++; $display("FAIL fifo_data[%0d] got %h exp %h", i, rd_log[6'(r0 + i)], exp_b[i]);
            end
        end
    endtask

    task automatic test_write_stall();
        int gap, f0, d0, w0;
        wr_tab[0] = 8'hA5; wr_tab[1] = 8'h3C;
        f0 = ncs_falls; d0 = done_cnt; w0 = wrr_cnt;
        // Hold wr_valid low through the first data byte and then ~50 more cycles
        do_xfer(2'd0, 6'h01, 5'd2, 50 + 16 * int'(CLK_DIV), gap);
        checks++; if (mb_n != 4) begin errors++; $display("FAIL stall_nbytes got %0d exp 4", mb_n); end
        checks++; if (mb[2] !== 8'hA5) begin errors++; $display("FAIL stall_data0 got %h exp A5", mb[2]); end
        checks++; if (mb[3] !== 8'h3C) begin errors++; $display("FAIL stall_data1 got %h exp 3C", mb[3]); end
        checks++; if (ncs_falls - f0 != 1) begin errors++; $display("FAIL stall_ncs_falls got %0d exp 1", ncs_falls - f0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stall_done_count got %0d exp 1", done_cnt - d0); end
        checks++; if (wrr_cnt - w0 != 2) begin errors++; $display("FAIL stall_wr_ready_count got %0d exp 2", wrr_cnt - w0); end
        checks++; if (low_max < 50) begin errors++; $display("FAIL stall_low_len got %0d exp >=50", low_max); end
        checks++; if (high_bad != 0) begin errors++; $display("FAIL stall_high_phase bad %0d exp 0", high_bad); end
        checks++; if (mosi_bad != 0) begin errors++; $display("FAIL stall_mosi_while_high got %0d exp 0", mosi_bad); end
    endtask

    task automatic test_reset_mid();
        int n, d0, r0, gap;
        bus.cmd_op = 2'd1; bus.cmd_addr = 6'h15; bus.cmd_len = 5'd2;
        issue_cmd(2'd1, 6'h15, 5'd2);
        n = 0;
        while (nCS !== 1'b0 && n < 100) begin @(negedge clk_sys); n++; end
        @(negedge clk_sys);
        n = 0;
        while (rises < 13 && n < 1000) begin @(negedge clk_sys); n++; end
        checks++; if (rises != 13) begin errors++; $display("FAIL mid_reach_bit got %0d exp 13", rises); end
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk_sys);
        checks++; if (nCS !== 1'b1) begin errors++; $display("FAIL mid_rst_ncs got %b exp 1", nCS); end
        checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL mid_rst_sclk got %b exp 0", SCLK); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", bus.busy); end
        rst = 1'b0;
        repeat (20) @(negedge clk_sys);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_rst_done got %0d exp %0d", done_cnt, d0); end
        miso_tab[2] = 8'h12; miso_tab[3] = 8'h34;
        r0 = rd_n; d0 = done_cnt;
        do_xfer(2'd1, 6'h00, 5'd2, 0, gap);
        checks++; if (rises != 32) begin errors++; $display("FAIL post_rst_rises got %0d exp 32", rises); end
        checks++; if (mb[0] !== 8'h0B) begin errors++; $display("FAIL post_rst_hdr got %h exp 0B", mb[0]); end
        checks++; if (rd_n - r0 != 2) begin errors++; $display("FAIL post_rst_rd_count got %0d exp 2", rd_n - r0); end
        checks++; if (rd_log[6'(r0)] !== 8'h12) begin errors++; $display("FAIL post_rst_rd0 got %h exp 12", rd_log[6'(r0)]); end
        checks++; if (rd_log[6'(r0 + 1)] !== 8'h34) begin errors++; $display("FAIL post_rst_rd1 got %h exp 34", rd_log[6'(r0 + 1)]); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL post_rst_done got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_op3();
        int f0, d0;
        f0 = ncs_falls; d0 = done_cnt;
        issue_cmd(2'd3, 6'h00, 5'd0);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL op3_busy got %b exp 1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL op3_done_early got %b exp 0", bus.done); end
        @(negedge clk_sys);
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL op3_done got %b exp 1", bus.done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL op3_cmd_ready got %b exp 1", bus.cmd_ready); end
        @(negedge clk_sys);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL op3_done_width got %b exp 0", bus.done); end
        checks++; if (ncs_falls != f0) begin errors++; $display("FAIL op3_ncs_activity got %0d exp %0d", ncs_falls, f0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL op3_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_len0_read();
        int gap, r0, d0;
        r0 = rd_n; d0 = done_cnt;
        do_xfer(2'd1, 6'h2A, 5'd0, 0, gap);
        checks++; if (rises != 16) begin errors++; $display("FAIL len0_rises got %0d exp 16", rises); end
        checks++; if (mb[1] !== 8'h2A) begin errors++; $display("FAIL len0_addr got %h exp 2A", mb[1]); end
        checks++; if (rd_n - r0 != 0) begin errors++; $display("FAIL len0_rd_count got %0d exp 0", rd_n - r0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL len0_done got %0d exp 1", done_cnt - d0); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 6'd0; bus.cmd_len = '0;
        bus.wr_data = 8'h00; bus.wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin miso_tab[i] = 8'h00; wr_tab[i] = 8'h00; end
        test_reset();
        test_reg_write();
        test_burst_read();
        test_fifo_read();
        test_write_stall();
        test_reset_mid();
        test_op3();
        test_len0_read();
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL sclk_idle_toggle got %0d exp 0", idle_bad); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
